// File: rtl/ext_serial_tx_fifo_pkg.sv
// Shared serial-peripheral types: bus data types, status-word bit positions,
// transmitter FSM states and the baud divisor helper.
package ext_serial_tx_fifo_pkg;

    typedef logic       Bit_t;
    typedef logic [7:0] Byte_t;

    typedef enum int unsigned {
        SERIAL_MODE_WRITE_READY = 0,
        SERIAL_MODE_READ_VALID  = 1
    } Serial_mode_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } SERIAL_TX_STATE_t;

    // Divisor rounded to the nearest whole clock count per bit.
    function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/ext_serial_tx_fifo_byte_fifo.sv
// Parameterised synchronous byte FIFO; a push while full is ignored and
// the head byte is presented combinationally on dout.
module byte_fifo
    import ext_serial_tx_fifo_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  Byte_t                    din,
    output Byte_t                    dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   count
);

    localparam int unsigned PtrW = $clog2(Depth);

    Byte_t            mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full    = (count == (PtrW+1)'(Depth));
        empty   = (count == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        dout    = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PtrW+1)'(1);
                2'b01:   count <= count - (PtrW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ext_serial_tx_fifo.sv
// Buffered 8N1 transmitter: bus writes queue into a byte FIFO and are shifted
// out on txd back-to-back, LSB first.
module ext_serial_tx_fifo
    import ext_serial_tx_fifo_pkg::*;
#(
    parameter int unsigned ClkFrequency = 25000000,
    parameter int unsigned Baud         = 115200,
    parameter int unsigned FifoDepth    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       write_op,
    input  logic [7:0] bus_data_write,
    output logic       tx_ready,
    output logic       tx_idle,
    output logic       txd
);

    localparam int unsigned Div  = baud_div(ClkFrequency, Baud);
    localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
    localparam logic [CntW-1:0] DivLast = CntW'(Div - 1);

    SERIAL_TX_STATE_t               state;
    logic [CntW-1:0]                baud_cnt;
    logic [2:0]                     bit_idx;
    Byte_t                          shift;
    Bit_t                           txd_q;

    Byte_t                          fifo_dout;
    logic                           fifo_full;
    logic                           fifo_empty;
    logic [$clog2(FifoDepth):0]     fifo_count;
    logic                           bit_end;
    logic                           pop;

    byte_fifo #(
        .Depth (FifoDepth)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (write_op),
        .pop   (pop),
        .din   (bus_data_write),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Pop must match exactly the cycles where the FSM loads the shifter.
    always_comb begin
        bit_end  = (baud_cnt == '0);
        pop      = !fifo_empty && ((state == TX_IDLE) || (state == TX_STOP && bit_end));
        tx_ready = !fifo_full;
        tx_idle  = (state == TX_IDLE) && (fifo_count == '0);
        txd      = txd_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= TX_IDLE;
            txd_q    <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            case (state)
                TX_IDLE: begin
                    txd_q <= 1'b1;
                    if (!fifo_empty) begin
                        shift    <= fifo_dout;
                        bit_idx  <= '0;
                        baud_cnt <= DivLast;
                        txd_q    <= 1'b0;
                        state    <= TX_START;
                    end
                end
                TX_START: begin
                    if (bit_end) begin
                        baud_cnt <= DivLast;
                        txd_q    <= shift[0];
                        state    <= TX_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - CntW'(1);
                    end
                end
                TX_DATA: begin
                    if (bit_end) begin
                        shift    <= shift >> 1;
                        bit_idx  <= bit_idx + 3'd1;
                        baud_cnt <= DivLast;
                        if (bit_idx == 3'd7) begin
                            txd_q <= 1'b1;
                            state <= TX_STOP;
                        end else begin
                            txd_q <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - CntW'(1);
                    end
                end
                TX_STOP: begin
                    if (bit_end) begin
                        if (!fifo_empty) begin
                            shift    <= fifo_dout;
                            bit_idx  <= '0;
                            baud_cnt <= DivLast;
                            txd_q    <= 1'b0;
                            state    <= TX_START;
                        end else begin
                            txd_q <= 1'b1;
                            state <= TX_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - CntW'(1);
                    end
                end
                default: begin
                    txd_q <= 1'b1;
                    state <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ext_serial_tx_fifo.sv
// Scoreboard bench: accepted writes queue expected bytes; a line monitor
// decodes txd frames and compares them against the queue.
module tb_ext_serial_tx_fifo;

    localparam int DIV   = 217;
    localparam int FRAME = 10 * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       write_op = 1'b0;
    logic [7:0] bus_data_write = 8'h00;
    logic       tx_ready;
    logic       tx_idle;
    logic       txd;

    ext_serial_tx_fifo #(
        .ClkFrequency (25000000),
        .Baud         (115200),
        .FifoDepth    (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .write_op       (write_op),
        .bus_data_write (bus_data_write),
        .tx_ready       (tx_ready),
        .tx_idle        (tx_idle),
        .txd            (txd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    int         fs_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Line monitor: decodes each frame at mid-bit and checks bits are stable.
    initial begin
        int       pos;
        logic     bitval;
        logic     glitch;
        logic [9:0] bits;
        logic     busy;
        busy = 1'b0;
        pos = 0; bitval = 1'b1; glitch = 1'b0; bits = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy = 1'b0;
            end else if (busy) begin
                pos++;
                if (pos % DIV == 0) bitval = txd;
                else if (txd !== bitval) glitch = 1'b1;
                if (pos % DIV == DIV / 2) bits[pos / DIV] = txd;
                if (pos == FRAME - 1) begin
                    busy = 1'b0;
                    check("frame_shape", {glitch, bits[0], bits[9]}, 3'b001);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_frame: got 0x%0h expected no frame", bits[8:1]);
                    end else begin
                        check("rx_byte", int'(bits[8:1]), int'(exp_q.pop_front()));
                    end
                end
            end else if (txd == 1'b0) begin
                busy = 1'b1;
                pos = 0;
                bitval = 1'b0;
                glitch = 1'b0;
                bits = '0;
                fs_q.push_back(cyc);
            end
        end
    end

    task automatic step(input logic we, input logic [7:0] d);
        @(posedge clk);
        #1;
        write_op = we;
        bus_data_write = d;
    endtask

    task automatic push(input logic [7:0] d, input logic accept);
        step(1'b1, d);
        if (accept) exp_q.push_back(d);
    endtask

    task automatic idle_to(input int c);
        while (cyc < c) step(1'b0, 8'h00);
    endtask

    task automatic wait_idle(input string name, input int bound, output int at);
        int i;
        i = 0;
        step(1'b0, 8'h00);
        while (!tx_idle && i < bound) begin
            step(1'b0, 8'h00);
            i++;
        end
        at = cyc;
        if (!tx_idle) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic expect_starts(input string name, input int first, input int n);
        check({name, "_frames"}, fs_q.size(), n);
        for (int k = 0; k < n && fs_q.size() > 0; k++) begin
            check({name, "_start"}, fs_q.pop_front(), first + k * FRAME);
        end
        fs_q.delete();
    endtask

    initial begin
        int t0;
        int at;
        int sent;
        int lows;

        // Reset state
        repeat (3) step(1'b0, 8'h00);
        check("reset_txd", txd, 1);
        check("reset_tx_ready", tx_ready, 1);
        check("reset_tx_idle", tx_idle, 1);
        rst = 1'b0;
        step(1'b0, 8'h00);

        // Single byte 0x55
        fs_q.delete();
        push(8'h55, 1'b1);
        t0 = cyc;
        step(1'b0, 8'h00);
        check("single_idle_drop", tx_idle, 0);
        check("single_txd_high_c1", txd, 1);
        step(1'b0, 8'h00);
        check("single_txd_fall_c2", txd, 0);
        wait_idle("single", 2 * FRAME, at);
        check("single_idle_return", at, t0 + 2 + FRAME);
        expect_starts("single", t0 + 2, 1);

        // Back-to-back 0xA5, 0x3C
        push(8'hA5, 1'b1);
        t0 = cyc;
        push(8'h3C, 1'b1);
        wait_idle("b2b", 3 * FRAME, at);
        check("b2b_idle_return", at, t0 + 2 + 2 * FRAME);
        expect_starts("b2b", t0 + 2, 2);

        // Full FIFO: 0x06 dropped
        push(8'h01, 1'b1);
        t0 = cyc;
        push(8'h02, 1'b1);
        push(8'h03, 1'b1);
        push(8'h04, 1'b1);
        push(8'h05, 1'b1);
        check("full_ready_before_5th", tx_ready, 1);
        push(8'h06, 1'b0);
        check("full_ready_drop", tx_ready, 0);
        step(1'b0, 8'h00);
        check("full_ready_held", tx_ready, 0);
        wait_idle("full", 6 * FRAME, at);
        check("full_idle_return", at, t0 + 2 + 5 * FRAME);
        expect_starts("full", t0 + 2, 5);

        // Pointer wrap: stream 12 bytes as space allows
        sent = 0;
        for (int i = 0; i < 14 * FRAME && sent < 12; i++) begin
            @(posedge clk);
            #1;
            if (tx_ready) begin
                write_op = 1'b1;
                bus_data_write = 8'h30 + 8'(sent);
                exp_q.push_back(8'h30 + 8'(sent));
                sent++;
            end else begin
                write_op = 1'b0;
            end
        end
        check("wrap_sent", sent, 12);
        wait_idle("wrap", 14 * FRAME, at);
        check("wrap_frames", fs_q.size(), 12);
        fs_q.delete();

        // Reset during data bit 3 of 0xFF with two bytes queued
        push(8'hFF, 1'b0);
        t0 = cyc;
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        step(1'b0, 8'h00);
        idle_to(t0 + 2 + 4 * DIV + 99);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_txd", txd, 1);
        check("rst_mid_tx_ready", tx_ready, 1);
        check("rst_mid_tx_idle", tx_idle, 1);
        fs_q.delete();
        lows = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b0, 8'h00);
            if (txd !== 1'b1) lows++;
        end
        check("rst_mid_line_quiet", lows, 0);
        check("rst_mid_no_frames", fs_q.size(), 0);

        // Push rejected in the cycle of the STOP-end pop while full
        push(8'h10, 1'b1);
        t0 = cyc;
        push(8'h11, 1'b1);
        push(8'h12, 1'b1);
        push(8'h13, 1'b1);
        push(8'h14, 1'b1);
        step(1'b0, 8'h00);
        idle_to(t0 + FRAME);
        push(8'h99, 1'b0);
        check("bound_full_at_stop_end", tx_ready, 0);
        check("bound_txd_stop", txd, 1);
        push(8'hAB, 1'b1);
        check("bound_ready_after_pop", tx_ready, 1);
        check("bound_next_start", txd, 0);
        step(1'b0, 8'h00);
        check("bound_full_again", tx_ready, 0);
        wait_idle("bound", 7 * FRAME, at);
        check("bound_idle_return", at, t0 + 2 + 6 * FRAME);
        expect_starts("bound", t0 + 2, 6);

        repeat (4) step(1'b0, 8'h00);
        check("leftover_expected", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
